// File: rtl/ram_scan_pkg.sv
// Shared widths and scan FSM encoding for the RAM scan controller.
package ram_scan_pkg;

    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned DATA_WIDTH = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} scan_state_t;

endpackage

// File: rtl/ram_scan_controller_step_timer.sv
// Free-running scan step timer: one-cycle step pulse every TICKS_PER_STEP clocks.
module step_timer #(
    parameter int unsigned TICKS_PER_STEP = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic step
);

    localparam int unsigned CW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_STEP - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign step = (cnt_q == LAST);

endmodule

// File: rtl/ram_scan_controller.sv
// Scans the RAM read port once per step, turns key presses into single write strobes and
// hands a coherent (address, data) pair to the display stage.
module ram_scan_controller
    import ram_scan_pkg::*;
#(
    parameter int unsigned TICKS_PER_STEP = 50_000_000,
    parameter int unsigned RD_LATENCY     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_key,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] ram_wraddress,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_wren,
    output logic [ADDR_WIDTH-1:0] ram_rdaddress,
    output logic [ADDR_WIDTH-1:0] disp_addr,
    output logic [DATA_WIDTH-1:0] disp_data,
    output logic                  disp_valid,
    output logic                  step
);

    localparam int unsigned LW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [LW-1:0] LAT_INIT = LW'(RD_LATENCY - 1);

    scan_state_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0] scan_q, scan_d;
    logic [LW-1:0]         lat_q, lat_d;
    logic                  key_q, key_prev_q, key_rise;
    logic                  wr_hit, capture;

    step_timer #(
        .TICKS_PER_STEP(TICKS_PER_STEP)
    ) u_step_timer (
        .clk  (clk),
        .reset(reset),
        .step (step)
    );

    assign key_rise      = key_q & ~key_prev_q;
    assign wr_hit        = ram_wren && (ram_wraddress == scan_q);
    assign ram_rdaddress = scan_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_q         <= 1'b0;
            key_prev_q    <= 1'b0;
            ram_wren      <= 1'b0;
            ram_wraddress <= '0;
            ram_data      <= '0;
        end else begin
            key_q      <= wr_key;
            key_prev_q <= key_q;
            ram_wren   <= key_rise;
            if (key_rise) begin
                ram_wraddress <= wr_addr;
                ram_data      <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ISSUE;
            scan_q  <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            scan_q  <= scan_d;
            lat_q   <= lat_d;
        end
    end

    // A step, or a write landing on the address being read, restarts the read; step wins.
    always_comb begin
        state_d = state_q;
        scan_d  = scan_q;
        if (step) begin
            scan_d  = scan_q + ADDR_WIDTH'(1);
            state_d = ISSUE;
        end else if (wr_hit) begin
            state_d = ISSUE;
        end else begin
            unique case (state_q)
                IDLE:    state_d = IDLE;
                ISSUE:   state_d = (RD_LATENCY > 1) ? WAIT : CAPTURE;
                WAIT:    state_d = (lat_q <= LW'(1)) ? CAPTURE : WAIT;
                CAPTURE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // rd_data in CAPTURE predates a same-cycle write to this address, so drop it.
    always_comb begin
        lat_d   = lat_q;
        capture = 1'b0;
        unique case (state_q)
            ISSUE:   lat_d = LAT_INIT;
            WAIT:    lat_d = lat_q - LW'(1);
            CAPTURE: capture = !wr_hit;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_addr  <= '0;
            disp_data  <= '0;
            disp_valid <= 1'b0;
        end else if (capture) begin
            disp_addr  <= scan_q;
            disp_data  <= rd_data;
            disp_valid <= 1'b1;
        end
    end

endmodule
